// File: rtl/keypad_scan.sv
// keypad_scan: autonomous 4x4 keypad scanner with debounce, 4-entry key FIFO and Avalon-MM slave.
// Optional KEYPAD_SCAN_IRQ_EN adds a registered interrupt while the FIFO holds keys.
module keypad_scan #(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] address,
    input  logic       chipselect,
    input  logic       read_n,
    input  logic       write_n,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic       irq
);
    localparam int unsigned DIV_W      = $clog2(CLK_DIV);
    localparam int unsigned DEB_W      = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, HELD} state_t;

    state_t             state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [1:0]         row_q, row_d;
    logic [DEB_W-1:0]   deb_q, deb_d, deb_inc_c;
    logic [3:0]         col_n_d;
    logic [3:0]         push_code_c;
    logic               push_c;

    logic [3:0]         rows_meta, rows_s, rows_low_c;
    logic               single_low_c, same_row_c;
    logic [1:0]         row_enc_c;

    logic [DIV_W-1:0]   div_q;
    logic               run_c, tick_c;

    logic               scan_en;
    logic               irq_bit_c;
    logic               wr_c, rd_c, pop_c, push_ok_c, empty_c, full_c;

    logic [3:0]         mem_q [FIFO_DEPTH];
    logic [1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               overflow;

    assign wr_c = chipselect & ~write_n;
    assign rd_c = chipselect & ~read_n;

    // Two-flop synchronizer for the asynchronous keypad rows
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rows_meta <= 4'hF;
            rows_s    <= 4'hF;
        end else begin
            rows_meta <= row_n;
            rows_s    <= rows_meta;
        end
    end

    // Scan tick divider; held at 0 until a column is actually being driven
    assign run_c  = scan_en && (state_q != IDLE);
    assign tick_c = run_c && (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else if (!run_c || tick_c) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Row decode: exactly one row low is a candidate key, anything else is noise or ghosting
    assign rows_low_c   = ~rows_s;
    assign single_low_c = (rows_low_c != 4'h0) && ((rows_low_c & (rows_low_c - 4'h1)) == 4'h0);
    assign same_row_c   = (rows_s == ~(4'b0001 << row_q));
    assign deb_inc_c    = deb_q + DEB_W'(1);

    always_comb begin
        row_enc_c = 2'd0;
        case (rows_low_c)
            4'b0010: row_enc_c = 2'd1;
            4'b0100: row_enc_c = 2'd2;
            4'b1000: row_enc_c = 2'd3;
            default: row_enc_c = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            deb_q   <= '0;
            col_n   <= 4'hF;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            deb_q   <= deb_d;
            col_n   <= col_n_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        deb_d       = deb_q;
        push_c      = 1'b0;
        push_code_c = {row_q, col_q};

        if (!scan_en) begin
            state_d = IDLE;
            col_d   = 2'd0;
            deb_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SCAN;
                    col_d   = 2'd0;
                    deb_d   = '0;
                end
                SCAN: begin
                    if (tick_c) begin
                        if (single_low_c) begin
                            row_d       = row_enc_c;
                            push_code_c = {row_enc_c, col_q};
                            if (DEBOUNCE_TICKS == 1) begin
                                push_c  = 1'b1;
                                state_d = HELD;
                                deb_d   = '0;
                            end else begin
                                state_d = DEBOUNCE;
                                deb_d   = DEB_W'(1);
                            end
                        end else begin
                            col_d = col_q + 2'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tick_c) begin
                        if (same_row_c) begin
                            if (deb_inc_c == DEB_W'(DEBOUNCE_TICKS)) begin
                                push_c  = 1'b1;
                                state_d = HELD;
                                deb_d   = '0;
                            end else begin
                                deb_d = deb_inc_c;
                            end
                        end else begin
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                            deb_d   = '0;
                        end
                    end
                end
                HELD: begin
                    if (tick_c) begin
                        if (rows_s == 4'hF) begin
                            if (deb_inc_c == DEB_W'(DEBOUNCE_TICKS)) begin
                                state_d = SCAN;
                                col_d   = col_q + 2'd1;
                                deb_d   = '0;
                            end else begin
                                deb_d = deb_inc_c;
                            end
                        end else begin
                            deb_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        col_n_d = (state_d == IDLE) ? 4'hF : ~(4'b0001 << col_d);
    end

    // Key FIFO; a pop frees a slot for a simultaneous push even when full
    assign empty_c   = (count_q == '0);
    assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_c     = rd_c && (address == 2'd0) && !empty_c;
    assign push_ok_c = push_c && (!full_c || pop_c);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 4'h0;
            end
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_ptr] <= push_code_c;
                wr_ptr        <= wr_ptr + 2'd1;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count_q <= count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
            if (push_c && !push_ok_c) begin
                overflow <= 1'b1;
            end else if (wr_c && (address == 2'd1)) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_en <= 1'b0;
        end else if (wr_c && (address == 2'd2)) begin
            scan_en <= writedata[0];
        end
    end

`ifdef KEYPAD_SCAN_IRQ_EN
    logic irq_en;
    logic unused_wd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_c && (address == 2'd2)) begin
                irq_en <= writedata[1];
            end
            irq <= irq_en && !empty_c;
        end
    end

    assign irq_bit_c = irq_en;
    assign unused_wd = ^writedata[7:2];
`else
    logic unused_wd;

    assign irq       = 1'b0;
    assign irq_bit_c = 1'b0;
    assign unused_wd = ^writedata[7:1];
`endif

    always_comb begin
        readdata = 8'h00;
        case (address)
            2'd0:    readdata = {3'b000, !empty_c, (empty_c ? 4'h0 : mem_q[rd_ptr])};
            2'd1:    readdata = {4'b0000, overflow, count_q};
            2'd2:    readdata = {6'b000000, irq_bit_c, scan_en};
            default: readdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed test of keypad_scan with CLK_DIV=4, DEBOUNCE_TICKS=3 and a behavioural keypad.
module tb_keypad_scan;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEB     = 3;
`ifdef KEYPAD_SCAN_IRQ_EN
    localparam logic IRQ_EXP  = 1'b1;
    localparam logic [7:0] CTRL_EXP = 8'h03;
`else
    localparam logic IRQ_EXP  = 1'b0;
    localparam logic [7:0] CTRL_EXP = 8'h01;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] address;
    logic       chipselect;
    logic       read_n;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic       irq;

    logic       key_on;
    logic [1:0] key_r;
    logic [1:0] key_c;
    logic       ghost;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] seq [5];
    logic [7:0] d;
    int         n;

    keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DEB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .col_n      (col_n),
        .row_n      (row_n),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_n = 4'hF;
        if (ghost) begin
            row_n = 4'b1100;
        end else if (key_on && !col_n[key_c]) begin
            row_n[key_r] = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] wd);
        address    = a;
        writedata  = wd;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] rd);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        #1 rd = readdata;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic peek(input logic [1:0] a, output logic [7:0] rd);
        address = a;
        #1 rd = readdata;
    endtask

    task automatic wait_col_change(output int cycles);
        logic [3:0] prev;
        bit found;
        prev   = col_n;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            cycles++;
            if (col_n !== prev) found = 1'b1;
        end
        check_eq("col_change_seen", 8'(found), 8'd1);
    endtask

    task automatic wait_col(input logic [3:0] target);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            prev = col_n;
            @(negedge clk);
            if (col_n === target && prev !== target) found = 1'b1;
        end
        check_eq("col_reached", 8'(found), 8'd1);
    endtask

    task automatic press_key(input logic [1:0] r, input logic [1:0] c);
        key_r  = r;
        key_c  = c;
        key_on = 1'b1;
        repeat (60) @(negedge clk);
        key_on = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        bit found;
        seq[0] = 4'hD; seq[1] = 4'hB; seq[2] = 4'h7; seq[3] = 4'hE; seq[4] = 4'hD;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        writedata = 8'h00; key_on = 1'b0; key_r = 2'd0; key_c = 2'd0; ghost = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_col_n", 8'(col_n), 8'h0F);
        check_eq("rst_irq", 8'(irq), 8'h00);
        peek(2'd0, rd); check_eq("rst_data", rd, 8'h00);
        peek(2'd1, rd); check_eq("rst_status", rd, 8'h00);
        peek(2'd2, rd); check_eq("rst_control", rd, 8'h00);

        // Column sweep E,D,B,7,E,D with 4-clk hold each
        bus_write(2'd2, 8'h01);
        wait_col(4'hE);
        check_eq("scan_first_col", 8'(col_n), 8'h0E);
        for (int k = 0; k < 5; k++) begin
            wait_col_change(n);
            check_eq("col_hold", 8'(n), 8'd4);
            check_eq("col_seq", 8'(col_n), 8'(seq[k]));
        end
        peek(2'd2, rd); check_eq("ctrl_en", rd, 8'h01);
        bus_write(2'd2, 8'h00);
        @(negedge clk);
        check_eq("disable_col_n", 8'(col_n), 8'h0F);

        // Single key r=1 c=2 pressed and read back
        key_r = 2'd1; key_c = 2'd2; key_on = 1'b1;
        bus_write(2'd2, 8'h03);
        peek(2'd2, rd); check_eq("ctrl_irq_bit", rd, CTRL_EXP);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            peek(2'd1, rd);
            if (rd[2:0] != 3'd0) found = 1'b1;
        end
        check_eq("press_seen", 8'(found), 8'd1);
        check_eq("irq_lag", 8'(irq), 8'h00);
        @(negedge clk);
        check_eq("irq_set", 8'(irq), 8'(IRQ_EXP));
        key_on = 1'b0;
        peek(2'd1, rd); check_eq("press_status", rd, 8'h01);
        bus_read(2'd0, rd); check_eq("press_data", rd, 8'h16);
        check_eq("irq_hold_after_pop", 8'(irq), 8'(IRQ_EXP));
        peek(2'd0, rd); check_eq("post_pop_data", rd, 8'h00);
        peek(2'd1, rd); check_eq("post_pop_status", rd, 8'h00);
        @(negedge clk);
        check_eq("irq_clear", 8'(irq), 8'h00);
        repeat (30) @(negedge clk);

        // Bounce: low for 2 ticks, then released before the third
        bus_write(2'd2, 8'h00);
        @(negedge clk);
        bus_write(2'd2, 8'h03);
        key_r = 2'd1; key_c = 2'd2; key_on = 1'b0;
        wait_col(4'hB);
        key_on = 1'b1;
        repeat (8) @(negedge clk);
        key_on = 1'b0;
        wait_col_change(n);
        check_eq("bounce_hold", 8'(n), 8'd4);
        check_eq("bounce_next_col", 8'(col_n), 8'h07);
        peek(2'd1, rd); check_eq("bounce_no_push", rd, 8'h00);

        // Ghosting: two rows low never accepted, scanning continues
        bus_write(2'd2, 8'h00);
        ghost = 1'b1;
        @(negedge clk);
        bus_write(2'd2, 8'h03);
        wait_col(4'hE);
        for (int k = 0; k < 5; k++) begin
            wait_col_change(n);
            check_eq("ghost_hold", 8'(n), 8'd4);
            check_eq("ghost_seq", 8'(col_n), 8'(seq[k]));
        end
        peek(2'd1, rd); check_eq("ghost_no_push", rd, 8'h00);
        ghost = 1'b0;
        repeat (30) @(negedge clk);

        // Overflow: five presses, four kept in order
        press_key(2'd0, 2'd0);
        press_key(2'd1, 2'd1);
        press_key(2'd2, 2'd3);
        press_key(2'd3, 2'd0);
        press_key(2'd3, 2'd3);
        peek(2'd1, rd); check_eq("ovf_status", rd, 8'h0C);
        bus_read(2'd0, rd); check_eq("ovf_rd0", rd, 8'h10);
        bus_read(2'd0, rd); check_eq("ovf_rd1", rd, 8'h15);
        bus_read(2'd0, rd); check_eq("ovf_rd2", rd, 8'h1B);
        bus_read(2'd0, rd); check_eq("ovf_rd3", rd, 8'h1C);
        peek(2'd1, rd); check_eq("ovf_sticky", rd, 8'h08);
        bus_read(2'd0, rd); check_eq("empty_read", rd, 8'h00);
        peek(2'd1, rd); check_eq("empty_read_status", rd, 8'h08);
        bus_write(2'd1, 8'h00);
        peek(2'd1, rd); check_eq("ovf_cleared", rd, 8'h00);

        // Full FIFO: pop coinciding with push keeps count at 4, no overflow
        press_key(2'd0, 2'd1);
        press_key(2'd0, 2'd2);
        press_key(2'd0, 2'd3);
        press_key(2'd1, 2'd0);
        peek(2'd1, rd); check_eq("full_status", rd, 8'h04);
        key_r = 2'd2; key_c = 2'd1; key_on = 1'b0;
        wait_col(4'hD);
        key_on = 1'b1;
        repeat (11) @(negedge clk);
        bus_read(2'd0, rd); check_eq("pushpop_data", rd, 8'h11);
        key_on = 1'b0;
        peek(2'd1, rd); check_eq("pushpop_status", rd, 8'h04);
        bus_read(2'd0, rd); check_eq("pp_rd1", rd, 8'h12);
        bus_read(2'd0, rd); check_eq("pp_rd2", rd, 8'h13);
        bus_read(2'd0, rd); check_eq("pp_rd3", rd, 8'h14);
        bus_read(2'd0, rd); check_eq("pp_rd4", rd, 8'h19);
        peek(2'd1, rd); check_eq("pp_final_status", rd, 8'h00);
        check_eq("final_irq", 8'(irq), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Autonomous 4x4 matrix-keypad scanner with an Avalon-MM slave port for the Nios II clock system. It drives the keypad columns (active-low, one at a time) and samples the rows. It debounces key presses and pushes a 4-bit key code into a 4-entry FIFO that the CPU reads. This replaces software column strobing through a plain output PIO.

## Interface
Parameters:
- CLK_DIV, 50000 — clk cycles per scan tick (1 ms at 50 MHz); minimum 2.
- DEBOUNCE_TICKS, 20 — consecutive stable ticks needed to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  8  write data
- readdata  out  8  read data, combinational from address
- col_n  out  4  column drive, active-low, one-hot-low while scanning
- row_n  in  4  raw keypad rows, asynchronous, active-low (pulled up)
- irq  out  1  interrupt request (only with KEYPAD_SCAN_IRQ_EN)

## Operation
- Registers (unused bits read 0):
  - Address 0 DATA: bit4 = FIFO not empty; bits3:0 = head key code (0 when empty). A read with chipselect & ~read_n & address==0 pops one entry at that clk edge. A read when empty has no effect.
  - Address 1 STATUS: bits2:0 = FIFO count (0..4); bit3 = sticky overflow. Any write to address 1 clears overflow.
  - Address 2 CONTROL: bit0 = scan enable (reset 0); bit1 = irq enable (reset 0; read as 0 without the macro). Read/write.
  - Address 3: reads 0; writes ignored.
- row_n passes through a 2-flop synchronizer (rows_s). Decisions use rows_s only.
- Tick: a divider counts 0..CLK_DIV-1 while enabled and asserts tick for one clk at CLK_DIV-1. The divider is held at 0 while disabled.
- State machine:
  - IDLE: col_n=4'hF; col index 0. Goes to SCAN when enable=1.
  - SCAN: col_n=~(1<<col). On tick:
    - Exactly one rows_s bit low: latch row index r and column c, set deb_cnt=1, go DEBOUNCE.
    - Otherwise (no bit low, or ≥2 bits low as ghosting): col=col+1 mod 4.
  - DEBOUNCE: on tick:
    - Same single row low: deb_cnt++.
    - Anything else: go SCAN with col+1.
    - When deb_cnt reaches DEBOUNCE_TICKS, push code r*4+c and go HELD with deb_cnt=0.
    - With DEBOUNCE_TICKS=1, the push happens on the same tick that enters DEBOUNCE.
  - HELD: column stays driven. On tick:
    - rows_s==4'hF: deb_cnt++.
    - Otherwise: deb_cnt=0.
    - At DEBOUNCE_TICKS, go SCAN with col+1.
  - Clearing enable in any state forces IDLE on the next edge. FIFO and overflow are retained.
- FIFO: 4 entries, 4 bits each.
  - Push when full: the code is dropped and overflow is set.
  - Push and pop on the same edge: both occur, count unchanged (valid when full, since the pop frees a slot).
- Reset: col_n=4'hF, readdata reflects empty FIFO, irq=0, count=0, overflow=0, state IDLE.

## Timing
- Row change to rows_s: 2 clk.
- Press accepted after DEBOUNCE_TICKS stable ticks. The push lands on the edge ending that tick; DATA/STATUS show it on the following cycle.
- readdata is combinational from address and current registers; zero wait states. The pop is visible the cycle after the read.
- col_n changes on the edge ending the tick that advances col. Each column is driven for at least CLK_DIV cycles.
- Divider width: $clog2(CLK_DIV). deb_cnt width: $clog2(DEBOUNCE_TICKS+1).

## Configuration
- KEYPAD_SCAN_IRQ_EN defined:
  - irq = CONTROL.bit1 & (count!=0), registered (1-cycle lag after the push or pop edge).
  - CONTROL.bit1 is writable.
- Not defined:
  - irq tied 0.
  - CONTROL.bit1 is not stored and reads 0.

## Test plan
All scenarios use CLK_DIV=4, DEBOUNCE_TICKS=3.
- Reset then enable=1: col_n cycles E,D,B,7,E…, each held 4 clk. After write enable=0: col_n=F within 1 clk.
- Hold row_n=4'b1101 whenever col_n=4'hB (key r=1, c=2) for ≥3 ticks: STATUS count=1; DATA reads 0x16; after that read, DATA=0x00 and count=0.
- Bounce: row low for 2 ticks then high: no push; scanning resumes at the next column.
- Hold two rows low (4'b1100): never pushed; col_n keeps advancing.
- Five debounced presses without reads: count=4, overflow=1, first four codes read back in order. Write address 1: overflow=0. A pop coinciding with a push at count=4 leaves count=4 and overflow unchanged.
- With KEYPAD_SCAN_IRQ_EN: irq enable=1, one press: irq=1 one cycle after the push; it drops one cycle after the pop. Without the macro: irq stays 0 throughout.
